ahb_bus_arbiter: RTL and testbench

- Round-robin arbiter that shares one AHB address/data bus among NO_OF_MASTERS managers.
- Sits between the master agents and the master-to-slave multiplexer, driving the grant vector and the owner ID (hmaster) used to steer the address and data muxes.
- Holds ownership through fixed-length bursts, undefined INCR bursts and locked sequences.
- Re-arbitrates only at legal transfer boundaries qualified by hready.

---
 rtl/ahb_bus_arbiter.sv | 173 +++++++++++++++++
 tb/tb_ahb_bus_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB bus arbiter: grants one manager per address phase and holds ownership
// through fixed bursts, undefined-length INCR bursts and locked sequences.
module ahb_bus_arbiter #(
  parameter int unsigned NO_OF_MASTERS  = 2,
  parameter int unsigned HMASTER_WIDTH  = (NO_OF_MASTERS == 1) ? 1 : $clog2(NO_OF_MASTERS),
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input  logic                     hclk,
  input  logic                     hresetn,
  input  logic [NO_OF_MASTERS-1:0] hbusreq,
  input  logic [NO_OF_MASTERS-1:0] hlock,
  input  logic [1:0]               htrans,
  input  logic [2:0]               hburst,
  input  logic                     hready,
  output logic [NO_OF_MASTERS-1:0] hgrant,
  output logic [HMASTER_WIDTH-1:0] hmaster,
  output logic [HMASTER_WIDTH-1:0] hmaster_data,
  output logic                     hmastlock,
  output logic                     burst_active
);

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic [2:0] BURST_SINGLE = 3'd0;
  localparam logic [2:0] BURST_INCR   = 3'd1;
  localparam logic [2:0] BURST_WRAP4  = 3'd2;
  localparam logic [2:0] BURST_INCR4  = 3'd3;
  localparam logic [2:0] BURST_WRAP8  = 3'd4;
  localparam logic [2:0] BURST_INCR8  = 3'd5;
  localparam logic [2:0] BURST_WRAP16 = 3'd6;
  localparam logic [2:0] BURST_INCR16 = 3'd7;

  localparam logic [NO_OF_MASTERS-1:0] DEFAULT_GRANT =
    NO_OF_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [HMASTER_WIDTH-1:0] DEFAULT_ID = HMASTER_WIDTH'(DEFAULT_MASTER);

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_BURST  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       undef_q, undef_d;
  logic [HMASTER_WIDTH-1:0]   rr_q, rr_d;
  logic [NO_OF_MASTERS-1:0]   grant_d;
  logic [HMASTER_WIDTH-1:0]   master_d, mdata_d;
  logic                       mlock_d;

  logic [HMASTER_WIDTH-1:0]   winner, cand;
  logic                       win_found;
  logic                       handover;
  logic                       is_idle, is_nonseq, is_seq, is_fixed;
  logic [CNT_W-1:0]           burst_beats;

  assign is_idle   = (htrans == TRANS_IDLE);
  assign is_nonseq = (htrans == TRANS_NONSEQ);
  assign is_seq    = (htrans == TRANS_SEQ);
  assign is_fixed  = (hburst >= BURST_WRAP4);

  // Remaining SEQ beats after the NONSEQ that opens a fixed-length burst
  always_comb begin
    burst_beats = '0;
    unique case (hburst)
      BURST_WRAP4,  BURST_INCR4:  burst_beats = CNT_W'(3);
      BURST_WRAP8,  BURST_INCR8:  burst_beats = CNT_W'(7);
      BURST_WRAP16, BURST_INCR16: burst_beats = CNT_W'(15);
      default:                    burst_beats = '0;
    endcase
  end

  // Round-robin scan starting just after the last granted requester; park when idle
  always_comb begin
    win_found = 1'b0;
    winner    = DEFAULT_ID;
    cand      = '0;
    for (int unsigned k = 1; k <= NO_OF_MASTERS; k++) begin
      cand = HMASTER_WIDTH'((32'(rr_q) + k) % NO_OF_MASTERS);
      if (!win_found && hbusreq[cand]) begin
        win_found = 1'b1;
        winner    = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    undef_d  = undef_q;
    rr_d     = rr_q;
    grant_d  = hgrant;
    master_d = hmaster;
    mdata_d  = hmaster_data;
    mlock_d  = hmastlock;
    handover = 1'b0;

    if (hready) begin
      mdata_d = hmaster;
      unique case (state_q)
        ST_ARB: begin
          if (is_nonseq && (hburst != BURST_SINGLE)) begin
            state_d = ST_BURST;
            undef_d = (hburst == BURST_INCR);
            cnt_d   = burst_beats;
          end else begin
            handover = 1'b1;
          end
        end
        ST_BURST: begin
          if (undef_q) begin
            if (is_idle || is_nonseq || !hbusreq[hmaster]) handover = 1'b1;
          end else if (is_idle) begin
            handover = 1'b1;
          end else if (is_seq) begin
            if (cnt_q == CNT_W'(1)) begin
              cnt_d    = '0;
              handover = 1'b1;
            end else if (cnt_q != '0) begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        ST_LOCKED: begin
          if (is_nonseq && is_fixed)         cnt_d = burst_beats;
          else if (is_seq && (cnt_q != '0))  cnt_d = cnt_q - CNT_W'(1);
          if (!hlock[hmaster] && is_idle && (cnt_q == '0)) handover = 1'b1;
        end
        default: state_d = ST_ARB;
      endcase

      if (handover) begin
        grant_d         = '0;
        grant_d[winner] = 1'b1;
        master_d        = winner;
        mlock_d         = hlock[winner] & hbusreq[winner];
        cnt_d           = '0;
        undef_d         = 1'b0;
        state_d         = mlock_d ? ST_LOCKED : ST_ARB;
        if (win_found) rr_d = winner;
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q      <= ST_ARB;
      cnt_q        <= '0;
      undef_q      <= 1'b0;
      rr_q         <= DEFAULT_ID;
      hgrant       <= DEFAULT_GRANT;
      hmaster      <= DEFAULT_ID;
      hmaster_data <= DEFAULT_ID;
      hmastlock    <= 1'b0;
      burst_active <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      undef_q      <= undef_d;
      rr_q         <= rr_d;
      hgrant       <= grant_d;
      hmaster      <= master_d;
      hmaster_data <= mdata_d;
      hmastlock    <= mlock_d;
      burst_active <= (state_d == ST_BURST);
    end
  end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Scoreboard bench for ahb_bus_arbiter: directed cycles push expected outputs,
// a monitor pops and compares them on the falling edge.
module tb_ahb_bus_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned HW = 1;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  localparam logic [2:0] SINGLE = 3'd0;
  localparam logic [2:0] INCR   = 3'd1;
  localparam logic [2:0] INCR4  = 3'd3;
  localparam logic [2:0] WRAP8  = 3'd4;
  localparam logic [2:0] INCR16 = 3'd7;

  logic          hclk = 1'b0;
  logic          hresetn;
  logic [N-1:0]  hbusreq;
  logic [N-1:0]  hlock;
  logic [1:0]    htrans;
  logic [2:0]    hburst;
  logic          hready;
  logic [N-1:0]  hgrant;
  logic [HW-1:0] hmaster;
  logic [HW-1:0] hmaster_data;
  logic          hmastlock;
  logic          burst_active;

  ahb_bus_arbiter #(
    .NO_OF_MASTERS (N),
    .HMASTER_WIDTH (HW),
    .DEFAULT_MASTER(0)
  ) dut (
    .hclk         (hclk),
    .hresetn      (hresetn),
    .hbusreq      (hbusreq),
    .hlock        (hlock),
    .htrans       (htrans),
    .hburst       (hburst),
    .hready       (hready),
    .hgrant       (hgrant),
    .hmaster      (hmaster),
    .hmaster_data (hmaster_data),
    .hmastlock    (hmastlock),
    .burst_active (burst_active)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    string         name;
    logic [N-1:0]  grant;
    logic [HW-1:0] master;
    logic [HW-1:0] mdata;
    logic          lock;
    logic          ba;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  event        sample_ev;

  task automatic expect_out(input string nm, input logic [N-1:0] g, input logic [HW-1:0] m,
                            input logic [HW-1:0] md, input logic l, input logic ba);
    exp_t e;
    e.name = nm; e.grant = g; e.master = m; e.mdata = md; e.lock = l; e.ba = ba;
    exp_q.push_back(e);
  endtask

  // One bus cycle: drive on the falling edge, record what the outputs must be after the rising edge
  task automatic step(input string nm, input logic [N-1:0] req, input logic [N-1:0] lck,
                      input logic [1:0] trans, input logic [2:0] burst, input logic rdy,
                      input logic [N-1:0] g, input logic [HW-1:0] m, input logic [HW-1:0] md,
                      input logic l, input logic ba);
    @(negedge hclk);
    hbusreq = req; hlock = lck; htrans = trans; hburst = burst; hready = rdy;
    @(posedge hclk);
    expect_out(nm, g, m, md, l, ba);
  endtask

  // Assert reset in the middle of a clock phase so only an asynchronous reset can satisfy the check
  task automatic async_reset(input string nm);
    @(negedge hclk);
    #1;
    hresetn = 1'b0;
    hbusreq = '0; hlock = '0; htrans = IDLE; hburst = SINGLE; hready = 1'b1;
    #1;
    expect_out(nm, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    -> sample_ev;
    @(negedge hclk);
    hresetn = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    logic [N+2*HW+1:0] act, expv;
    forever begin
      @(negedge hclk or sample_ev);
      if (exp_q.size() > 0) begin
        e    = exp_q.pop_front();
        act  = {hgrant, hmaster, hmaster_data, hmastlock, burst_active};
        expv = {e.grant, e.master, e.mdata, e.lock, e.ba};
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got hgrant=%b hmaster=%0d hmaster_data=%0d hmastlock=%b burst_active=%b, expected hgrant=%b hmaster=%0d hmaster_data=%0d hmastlock=%b burst_active=%b",
                      e.name, hgrant, hmaster, hmaster_data, hmastlock, burst_active,
                      e.grant, e.master, e.mdata, e.lock, e.ba);
      end
    end
  end

  initial begin : stimulus
    hresetn = 1'b0;
    hbusreq = '0; hlock = '0; htrans = IDLE; hburst = SINGLE; hready = 1'b1;

    repeat (2) @(negedge hclk);
    #1;
    expect_out("reset", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    -> sample_ev;
    @(negedge hclk);
    hresetn = 1'b1;

    for (int i = 0; i < 10; i++)
      step("park", 2'b00, 2'b00, IDLE, SINGLE, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);

    // Both requesting SINGLE transfers: strict alternation, data owner one cycle behind
    step("rr0", 2'b11, 2'b00, NONSEQ, SINGLE, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    step("rr1", 2'b11, 2'b00, NONSEQ, SINGLE, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    step("rr2", 2'b11, 2'b00, NONSEQ, SINGLE, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    step("rr3", 2'b11, 2'b00, NONSEQ, SINGLE, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);

    // Master 0 INCR4 with BUSY and a wait state; owner drops its request mid-burst
    step("incr4_nonseq", 2'b11, 2'b00, NONSEQ, INCR4, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    step("incr4_seq1",   2'b10, 2'b00, SEQ,    INCR4, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    step("incr4_busy",   2'b10, 2'b00, BUSY,   INCR4, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    step("incr4_wait",   2'b10, 2'b00, SEQ,    INCR4, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    step("incr4_seq2",   2'b10, 2'b00, SEQ,    INCR4, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    step("incr4_last",   2'b10, 2'b00, SEQ,    INCR4, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);

    // Master 1 undefined INCR, releases its request after five beats
    step("incr_nonseq", 2'b11, 2'b00, NONSEQ, INCR, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)
      step("incr_seq", 2'b11, 2'b00, SEQ, INCR, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1);
    step("incr_drop_wait", 2'b01, 2'b00, SEQ, INCR, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1);
    step("incr_drop",      2'b01, 2'b00, SEQ, INCR, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);

    // Master 0 locked sequence with two WRAP8 bursts while master 1 keeps requesting
    step("lock_grant", 2'b01, 2'b01, IDLE, SINGLE, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    step("lock_wrap8a", 2'b11, 2'b01, NONSEQ, WRAP8, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++)
      step("lock_seq_a", 2'b11, 2'b01, SEQ, WRAP8, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    step("lock_idle_held", 2'b11, 2'b01, IDLE, SINGLE, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    step("lock_wrap8b", 2'b11, 2'b01, NONSEQ, WRAP8, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++)
      step("lock_seq_b", 2'b11, 2'b01, SEQ, WRAP8, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    step("lock_drop_nonseq", 2'b11, 2'b00, NONSEQ, SINGLE, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    step("lock_release",     2'b11, 2'b00, IDLE,   SINGLE, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);

    // Master 1 INCR16 interrupted by reset with nine beats left
    step("incr16_nonseq", 2'b11, 2'b00, NONSEQ, INCR16, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++)
      step("incr16_seq", 2'b11, 2'b00, SEQ, INCR16, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1);
    async_reset("reset_mid_burst");
    step("restart_0", 2'b11, 2'b00, NONSEQ, SINGLE, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    step("restart_1", 2'b11, 2'b00, NONSEQ, SINGLE, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);

    repeat (2) @(negedge hclk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
